// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Each grant captures ALUResult into a one-entry, id-tagged response register.
module alu_share_arbiter #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int OPCODE_LENGTH = 4,
   parameter  int NUM_REQ       = 2,
   localparam int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_a,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_b,
   input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0]  req_op,
   output logic [DATA_WIDTH-1:0]                  alu_src_a,
   output logic [DATA_WIDTH-1:0]                  alu_src_b,
   output logic [OPCODE_LENGTH-1:0]               alu_op,
   input  logic [DATA_WIDTH-1:0]                  alu_result,
   output logic                                   resp_valid,
   input  logic                                   resp_ready,
   output logic [DATA_WIDTH-1:0]                  resp_data,
   output logic [ID_W-1:0]                        resp_id
);

   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic [ID_W-1:0]       r_resp_id;
   logic [ID_W-1:0]       r_last;

   logic                  w_can_accept;
   logic                  w_any;
   logic                  w_grant;
   logic [ID_W-1:0]       w_win;
   logic [ID_W:0]         w_sum;

   assign w_can_accept = !r_resp_valid || resp_ready;

   // Search upward from last_grant+1, wrapping; first valid requester wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_sum = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_sum = {1'b0, r_last} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NUM_REQ))
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         if (!w_any && req_valid[w_sum[ID_W-1:0]]) begin
            w_any = 1'b1;
            w_win = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_grant = w_any && w_can_accept && reset;

   assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
   assign alu_src_a = w_grant ? req_a[w_win]  : '0;
   assign alu_src_b = w_grant ? req_b[w_win]  : '0;
   assign alu_op    = w_grant ? req_op[w_win] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_id    <= '0;
         r_last       <= ID_W'(NUM_REQ - 1);
      end else if (w_grant) begin
         r_resp_valid <= 1'b1;
         r_resp_data  <= alu_result;
         r_resp_id    <= w_win;
         r_last       <= w_win;
      end else if (r_resp_valid && resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_id    = r_resp_id;

endmodule
